// File: rtl/nibble_serial_subtractor_pkg.sv
// rtl/nibble_serial_subtractor_pkg.sv - shared constants and FSM state type for the serial subtractor
package nibble_serial_subtractor_pkg;

  localparam int WIDTH   = 16;
  localparam int DIGIT   = 4;
  localparam int NDIGITS = WIDTH / DIGIT;
  localparam int CNT_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// rtl/nibble_serial_subtractor_if.sv - operand/result bus with Run/Done handshake
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = nibble_serial_subtractor_pkg::WIDTH
);

  logic             Run;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             V;
  logic             Z;
  logic             Busy;
  logic             Done;

  modport master (
    output Run, A, B,
    input  D, Bout, V, Z, Busy, Done
  );

  modport slave (
    input  Run, A, B,
    output D, Bout, V, Z, Busy, Done
  );

endinterface

// File: rtl/nibble_serial_subtractor_digit_add.sv
// rtl/nibble_serial_subtractor_digit_add.sv - combinational one-digit adder with carry in/out
module nibble_serial_subtractor_digit_add #(
  parameter int W = nibble_serial_subtractor_pkg::DIGIT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - multi-cycle A - B, one digit per clock via A + ~B + 1
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = nibble_serial_subtractor_pkg::WIDTH,
  parameter int DIGIT = nibble_serial_subtractor_pkg::DIGIT
) (
  input  logic                       Clk,
  input  logic                       Reset,
  nibble_serial_subtractor_if.slave  bus
);

  // WIDTH must be a multiple of DIGIT; the last partial digit is not handled.
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int MSB  = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] dig_a, dig_b, dig_s;
  logic             dig_c;

  assign dig_a = a_q[cnt_q*DIGIT +: DIGIT];
  assign dig_b = nb_q[cnt_q*DIGIT +: DIGIT];

  nibble_serial_subtractor_digit_add #(
    .W (DIGIT)
  ) u_digit_add (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    nb_d    = nb_q;
    d_d     = d_q;
    bout_d  = bout_q;
    v_d     = v_q;
    z_d     = z_q;

    case (state_q)
      IDLE: begin
        if (bus.Run) begin
          a_d     = bus.A;
          nb_d    = ~bus.B;
          carry_d = 1'b1;
          d_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        d_d[cnt_q*DIGIT +: DIGIT] = dig_s;
        carry_d = dig_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Final carry out of A + ~B + 1 is the inverse of the borrow.
          bout_d  = ~dig_c;
          z_d     = (d_d == '0);
          v_d     = (a_q[MSB] == nb_q[MSB]) && (d_d[MSB] != a_q[MSB]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.Run) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b1;
      a_q     <= '0;
      nb_q    <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.D    = d_q;
  assign bus.Bout = bout_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - directed self-checking bench for the serial subtractor
module tb_nibble_serial_subtractor;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  nibble_serial_subtractor_if #(.WIDTH(16)) bus ();

  nibble_serial_subtractor #(
    .WIDTH (16),
    .DIGIT (4)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic [15:0] d, input logic bo,
                           input logic v, input logic z);
    chk({tag, "_D"}, bus.D, d);
    chk({tag, "_Bout"}, {15'd0, bus.Bout}, {15'd0, bo});
    chk({tag, "_V"}, {15'd0, bus.V}, {15'd0, v});
    chk({tag, "_Z"}, {15'd0, bus.Z}, {15'd0, z});
  endtask

  // Accept on edge 0, drop Run, check Busy through edges 0..3 and Done after edge 4.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    bus.A   = a;
    bus.B   = b;
    bus.Run = 1'b1;
    step();
    bus.Run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, {15'd0, bus.Busy}, 16'd1);
      chk({tag, "_nodone"}, {15'd0, bus.Done}, 16'd0);
      step();
    end
    chk({tag, "_done"}, {15'd0, bus.Done}, 16'd1);
    chk({tag, "_busy_off"}, {15'd0, bus.Busy}, 16'd0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    Reset   = 1'b1;
    bus.Run = 1'b1;
    bus.A   = 16'h1111;
    bus.B   = 16'h2222;
    step();
    step();
    chk("rst_busy", {15'd0, bus.Busy}, 16'd0);
    chk("rst_done", {15'd0, bus.Done}, 16'd0);
    chk_flags("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    Reset   = 1'b0;
    bus.Run = 1'b0;
    step();
    chk("idle_busy", {15'd0, bus.Busy}, 16'd0);

    run_op("t5m3", 16'h0005, 16'h0003);
    chk_flags("t5m3", 16'h0002, 1'b0, 1'b0, 1'b0);
    step();
    chk("t5m3_idle", {15'd0, bus.Done}, 16'd0);
    chk("t5m3_hold", bus.D, 16'h0002);

    run_op("t0m1", 16'h0000, 16'h0001);
    chk_flags("t0m1", 16'hFFFF, 1'b1, 1'b0, 1'b0);
    step();

    run_op("t8k", 16'h8000, 16'h0001);
    chk_flags("t8k", 16'h7FFF, 1'b0, 1'b1, 1'b0);
    step();

    run_op("t7f", 16'h7FFF, 16'hFFFF);
    chk_flags("t7f", 16'h8000, 1'b1, 1'b1, 1'b0);
    step();

    run_op("teq", 16'h1234, 16'h1234);
    chk_flags("teq", 16'h0000, 1'b0, 1'b0, 1'b1);
    step();

    // Operand change mid-run and Run held past Done.
    bus.A   = 16'h00F0;
    bus.B   = 16'h000F;
    bus.Run = 1'b1;
    step();
    chk("chg_clear", bus.D, 16'h0000);
    step();
    bus.A = 16'hFFFF;
    bus.B = 16'h1234;
    step();
    step();
    step();
    chk("chg_done", {15'd0, bus.Done}, 16'd1);
    chk_flags("chg", 16'h00E1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("held_done", {15'd0, bus.Done}, 16'd1);
      chk("held_busy", {15'd0, bus.Busy}, 16'd0);
      chk("held_D", bus.D, 16'h00E1);
    end
    bus.Run = 1'b0;
    step();
    chk("drop_done", {15'd0, bus.Done}, 16'd0);
    chk("drop_busy", {15'd0, bus.Busy}, 16'd0);
    chk("drop_D", bus.D, 16'h00E1);

    // Reset on the second RUN edge aborts the operation.
    bus.A   = 16'h0F0F;
    bus.B   = 16'h0101;
    bus.Run = 1'b1;
    step();
    bus.Run = 1'b0;
    step();
    chk("abort_busy_pre", {15'd0, bus.Busy}, 16'd1);
    chk("abort_partial", bus.D, 16'h000E);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("abort_busy", {15'd0, bus.Busy}, 16'd0);
    chk("abort_done", {15'd0, bus.Done}, 16'd0);
    chk("abort_D", bus.D, 16'h0000);
    step();
    chk("abort_stay", {15'd0, bus.Busy}, 16'd0);

    run_op("t9m4", 16'h0009, 16'h0004);
    chk_flags("t9m4", 16'h0005, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
